// File: rtl/mem_test_pkg.sv
// Shared types and helpers for the memory test sequencer.
// Holds the FSM state encoding, the word step and the pattern generator.
package mem_test_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_WAIT = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_WAIT = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_STEP  = DATA_W_DEF / 8;
    localparam int PAT_MAX_W  = 64;

    // Expected word at index idx; callers truncate to their data width.
    function automatic logic [PAT_MAX_W-1:0] next_pattern(
        input logic [PAT_MAX_W-1:0] pattern,
        input logic [PAT_MAX_W-1:0] idx
    );
        return pattern + idx;
    endfunction

endpackage

// File: rtl/mem_test_sequencer.sv
// Write-then-readback memory test driving a single-outstanding request/response
// master stage; reports mismatch count and first failing address.
module mem_test_sequencer
    import mem_test_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  word_cnt_i,
    input  logic [DATA_W-1:0] pattern_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [ADDR_W-1:0] first_err_addr_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic              req_write_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [DATA_W-1:0] req_wdata_o,
    input  logic              rsp_valid_i,
    input  logic [DATA_W-1:0] rsp_rdata_i
);

    // Byte stride per word, scaled from the package default width.
    localparam int STEP = ADDR_STEP * DATA_W / DATA_W_DEF;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  idx_q, cnt_q, err_cnt_q;
    logic [ADDR_W-1:0] base_q, first_err_q;
    logic [DATA_W-1:0] pattern_q;
    logic              aborted_q;

    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic              last_word, mismatch;
    logic              start_go, idx_inc, idx_clr, chk, set_ab;

    assign cur_addr  = base_q + ADDR_W'(idx_q) * ADDR_W'(STEP);
    assign cur_data  = DATA_W'(next_pattern(PAT_MAX_W'(pattern_q), PAT_MAX_W'(idx_q)));
    assign last_word = (idx_q == cnt_q - CNT_W'(1));
    assign mismatch  = (rsp_rdata_i != cur_data);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start_go = 1'b0;
        idx_inc  = 1'b0;
        idx_clr  = 1'b0;
        chk      = 1'b0;
        set_ab   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    start_go = 1'b1;
                    state_d  = (word_cnt_i != '0) ? S_WR_REQ : S_FINISH;
                end
            end
            S_WR_REQ: begin
                // A handshake commits the request even if abort is raised.
                if (req_ready_i) begin
                    state_d = S_WR_WAIT;
                end else if (abort_i) begin
                    set_ab  = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_WR_WAIT: begin
                if (rsp_valid_i) begin
                    if (abort_i) begin
                        set_ab  = 1'b1;
                        state_d = S_FINISH;
                    end else if (last_word) begin
                        idx_clr = 1'b1;
                        state_d = S_RD_REQ;
                    end else begin
                        idx_inc = 1'b1;
                        state_d = S_WR_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                if (req_ready_i) begin
                    state_d = S_RD_WAIT;
                end else if (abort_i) begin
                    set_ab  = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_RD_WAIT: begin
                if (rsp_valid_i) begin
                    chk = 1'b1;
                    if (abort_i || last_word) begin
                        set_ab  = abort_i;
                        state_d = S_FINISH;
                    end else begin
                        idx_inc = 1'b1;
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q       <= '0;
            cnt_q       <= '0;
            base_q      <= '0;
            pattern_q   <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            aborted_q   <= 1'b0;
        end else begin
            if (start_go) begin
                base_q      <= base_addr_i & ~ADDR_W'(3);
                cnt_q       <= word_cnt_i;
                pattern_q   <= pattern_i;
                idx_q       <= '0;
                err_cnt_q   <= '0;
                first_err_q <= '0;
                aborted_q   <= 1'b0;
            end else begin
                if (idx_clr) begin
                    idx_q <= '0;
                end else if (idx_inc) begin
                    idx_q <= idx_q + CNT_W'(1);
                end
                // err_cnt of zero marks that no mismatch has been recorded yet.
                if (chk && mismatch) begin
                    if (err_cnt_q == '0) begin
                        first_err_q <= cur_addr;
                    end
                    if (err_cnt_q != '1) begin
                        err_cnt_q <= err_cnt_q + CNT_W'(1);
                    end
                end
                if (set_ab) begin
                    aborted_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o           = (state_q != S_IDLE);
    assign done_o           = (state_q == S_FINISH);
    assign aborted_o        = aborted_q;
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_err_q;
    assign req_valid_o      = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
    assign req_write_o      = (state_q == S_WR_REQ);
    assign req_addr_o       = req_valid_o ? cur_addr : '0;
    assign req_wdata_o      = req_write_o ? cur_data : '0;

endmodule

// File: tb/tb_mem_test_sequencer.sv
// Directed bench for mem_test_sequencer with a negedge-driven memory model
// that logs every accepted request.
module tb_mem_test_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [31:0] base_addr, pattern;
    logic [15:0] word_cnt;
    logic        busy, done, aborted;
    logic [15:0] err_cnt;
    logic [31:0] first_err_addr;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [logic [31:0]];
    bit          log_wr [$];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    int          stall_left = 0;
    int          rsp_cnt    = 0;
    bit          corrupt_en = 0;
    logic [31:0] corrupt_addr = '0;
    logic [31:0] cap_addr, cap_data, pend_rdata;
    bit          cap_wr;

    mem_test_sequencer dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .base_addr_i(base_addr), .word_cnt_i(word_cnt), .pattern_i(pattern),
        .busy_o(busy), .done_o(done), .aborted_o(aborted), .err_cnt_o(err_cnt),
        .first_err_addr_o(first_err_addr), .req_valid_o(req_valid),
        .req_ready_i(req_ready), .req_write_o(req_write), .req_addr_o(req_addr),
        .req_wdata_o(req_wdata), .rsp_valid_i(rsp_valid), .rsp_rdata_i(rsp_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: ready one cycle after valid (plus optional stall), response two cycles after acceptance.
    always @(negedge clk) begin
        rsp_valid = 1'b0;
        if (rst) begin
            req_ready = 1'b0;
            rsp_cnt   = 0;
        end else begin
            if (rsp_cnt != 0) begin
                rsp_cnt = rsp_cnt - 1;
                if (rsp_cnt == 0) begin
                    rsp_valid = 1'b1;
                    rsp_rdata = pend_rdata;
                end
            end
            if (req_ready) begin
                req_ready = 1'b0;
                log_wr.push_back(cap_wr);
                log_addr.push_back(cap_addr);
                log_data.push_back(cap_data);
                if (cap_wr) mem[cap_addr] = cap_data;
                else if (corrupt_en && cap_addr == corrupt_addr) pend_rdata = '0;
                else if (mem.exists(cap_addr)) pend_rdata = mem[cap_addr];
                else pend_rdata = 32'hDEAD_BEEF;
                rsp_cnt = 2;
            end else if (req_valid && rsp_cnt == 0) begin
                if (stall_left != 0) begin
                    stall_left = stall_left - 1;
                end else begin
                    req_ready = 1'b1;
                    cap_wr    = req_write;
                    cap_addr  = req_addr;
                    cap_data  = req_wdata;
                end
            end
        end
    end

    task automatic do_start(input logic [31:0] b, input logic [15:0] c, input logic [31:0] p);
        log_wr.delete(); log_addr.delete(); log_data.delete();
        @(negedge clk);
        base_addr = b; word_cnt = c; pattern = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (done) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
        n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        n_checks++; if (first_err_addr !== 32'd0) begin n_fail++; $display("FAIL reset_first_err: got %h expected 0", first_err_addr); end
        n_checks++; if ({aborted, req_write, req_addr, req_wdata} !== '0) begin n_fail++; $display("FAIL reset_req_payload: got %h expected 0", {aborted, req_write, req_addr, req_wdata}); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [31:0] ea [4] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C};
        logic [31:0] ed [4] = '{32'hA5A5_0000, 32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003};
        bit ok;
        corrupt_en = 0;
        do_start(32'h8000_0000, 16'd4, 32'hA5A5_0000);
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_done: got timeout expected done pulse"); end
        n_checks++; if (log_addr.size() != 8) begin n_fail++; $display("FAIL basic_txn_count: got %0d expected 8", log_addr.size()); end
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            n_checks++;
            if (log_wr[i] !== (i < 4) || log_addr[i] !== ea[i % 4] ||
                (i < 4 && log_data[i] !== ed[i]) || (i >= 4 && log_data[i] !== 32'd0)) begin
                n_fail++;
                $display("FAIL basic_txn%0d: got wr=%b a=%h d=%h expected wr=%b a=%h d=%h",
                         i, log_wr[i], log_addr[i], log_data[i], (i < 4), ea[i % 4], (i < 4) ? ed[i % 4] : 32'd0);
            end
        end
        n_checks++; if (err_cnt !== 16'd0 || first_err_addr !== 32'd0 || aborted !== 1'b0) begin
            n_fail++; $display("FAIL basic_result: got err=%0d first=%h ab=%b expected 0 0 0", err_cnt, first_err_addr, aborted); end
        @(negedge clk); #1;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_after_done: got done=%b busy=%b expected 0 0", done, busy); end
    endtask

    task automatic test_corrupt;
        bit ok;
        corrupt_en = 1; corrupt_addr = 32'h8000_0008;
        do_start(32'h8000_0000, 16'd4, 32'hA5A5_0000);
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL corrupt_done: got timeout expected done pulse"); end
        n_checks++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL corrupt_err_cnt: got %0d expected 1", err_cnt); end
        n_checks++; if (first_err_addr !== 32'h8000_0008) begin n_fail++; $display("FAIL corrupt_first_err: got %h expected 80000008", first_err_addr); end
        corrupt_en = 0;
    endtask

    task automatic test_zero_count;
        do_start(32'h1234_0000, 16'd0, 32'h0);
        #1;
        n_checks++; if (done !== 1'b1 || busy !== 1'b1 || req_valid !== 1'b0) begin
            n_fail++; $display("FAIL zero_finish: got done=%b busy=%b valid=%b expected 1 1 0", done, busy, req_valid); end
        @(negedge clk); #1;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0 || err_cnt !== 16'd0 || log_addr.size() != 0) begin
            n_fail++; $display("FAIL zero_idle: got done=%b busy=%b err=%0d txns=%0d expected 0 0 0 0", done, busy, err_cnt, log_addr.size()); end
    endtask

    task automatic test_wrap;
        logic [31:0] ea [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        bit ok;
        do_start(32'hFFFF_FFF8, 16'd3, 32'h1234_5678);
        wait_done(ok);
        n_checks++; if (!ok || log_addr.size() != 6) begin n_fail++; $display("FAIL wrap_done: got ok=%b txns=%0d expected 1 6", ok, log_addr.size()); end
        for (int i = 0; i < 6 && i < log_addr.size(); i++) begin
            n_checks++; if (log_addr[i] !== ea[i % 3]) begin n_fail++; $display("FAIL wrap_addr%0d: got %h expected %h", i, log_addr[i], ea[i % 3]); end
        end
        n_checks++; if (err_cnt !== 16'd0 || aborted !== 1'b0) begin n_fail++; $display("FAIL wrap_result: got err=%0d ab=%b expected 0 0", err_cnt, aborted); end
    endtask

    task automatic test_stall_abort;
        bit ok;
        int guard;
        stall_left = 5;
        do_start(32'h2000_0000, 16'd4, 32'hCAFE_0000);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            n_checks++;
            if (req_valid !== 1'b1 || req_ready !== 1'b0 || req_write !== 1'b1 ||
                req_addr !== 32'h2000_0000 || req_wdata !== 32'hCAFE_0000) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v=%b r=%b w=%b a=%h d=%h expected 1 0 1 20000000 cafe0000",
                         i, req_valid, req_ready, req_write, req_addr, req_wdata);
            end
        end
        guard = 0;
        while (log_addr.size() < 2 && guard < 100) begin @(negedge clk); guard++; end
        abort = 1'b1;
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_done: got timeout expected done pulse"); end
        n_checks++; if (aborted !== 1'b1) begin n_fail++; $display("FAIL abort_flag: got %b expected 1", aborted); end
        abort = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        n_checks++; if (log_addr.size() != 2 || log_addr[1] !== 32'h2000_0004) begin
            n_fail++; $display("FAIL abort_txns: got %0d expected 2 ending at 20000004", log_addr.size()); end
        n_checks++; if (aborted !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_hold: got ab=%b busy=%b expected 1 0", aborted, busy); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int guard;
        corrupt_en = 1; corrupt_addr = 32'h3000_0000;
        do_start(32'h3000_0000, 16'd4, 32'h0F0F_0000);
        guard = 0;
        while (log_addr.size() < 6 && guard < 200) begin @(negedge clk); guard++; end
        #1;
        n_checks++; if (err_cnt !== 16'd1 || first_err_addr !== 32'h3000_0000) begin
            n_fail++; $display("FAIL mid_pre_reset: got err=%0d first=%h expected 1 30000000", err_cnt, first_err_addr); end
        rst = 1'b1;
        @(negedge clk); #1;
        n_checks++; if ({busy, done, aborted, req_valid, req_write, err_cnt, first_err_addr, req_addr, req_wdata} !== '0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got busy=%b done=%b err=%0d first=%h valid=%b expected all 0",
                               busy, done, err_cnt, first_err_addr, req_valid); end
        rst = 1'b0;
        corrupt_en = 0;
        do_start(32'h0000_1000, 16'd2, 32'h5555_0000);
        wait_done(ok);
        n_checks++; if (!ok || err_cnt !== 16'd0 || aborted !== 1'b0 || log_addr.size() != 4) begin
            n_fail++; $display("FAIL mid_rerun: got ok=%b err=%0d ab=%b txns=%0d expected 1 0 0 4", ok, err_cnt, aborted, log_addr.size()); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        base_addr = '0; word_cnt = '0; pattern = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
        test_reset();
        test_basic();
        test_corrupt();
        test_zero_count();
        test_wrap();
        test_stall_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
